adbg_axi_arbiter: RTL and testbench
===================================

// Module: adbg_axi_arbiter
// PURPOSE
//  Shares one single-beat AXI4 master port between NUM_REQ debug requesters (e.g. JTAG BIU, trace unit).
//  Each requester uses a simple req/gnt + rvalid interface; arbitration is round-robin, one transaction outstanding.
//  Sits in the axi_aclk domain between the debug units and the SoC interconnect.
// PARAMETERS
//  NUM_REQ         2   number of requesters (2..8)
//  AXI_ADDR_WIDTH  32  address width
//  AXI_DATA_WIDTH  64  data width (32 or 64)
//  AXI_ID_WIDTH    3   AXI ID width, >= clog2(NUM_REQ)
//  AXI_USER_WIDTH  6   AXI user width (driven 0)
// PORTS
//  axi_aclk        in   1                     clock
//  axi_aresetn     in   1                     reset, synchronous, active-low
//  req_i           in   NUM_REQ               per-requester request, held until gnt
//  we_i            in   NUM_REQ               1=write, 0=read
//  addr_i          in   NUM_REQ*ADDR          flattened addresses, requester k at [k*ADDR+:ADDR]
//  wdata_i         in   NUM_REQ*DATA          flattened write data, lane-aligned
//  be_i            in   NUM_REQ*DATA/8        flattened byte strobes
//  size_i          in   NUM_REQ*3             flattened AXI size codes
//  gnt_o           out  NUM_REQ               one-hot 1-cycle grant; fields sampled that edge
//  rvalid_o        out  NUM_REQ               one-hot 1-cycle completion pulse
//  rdata_o         out  DATA                  read data, valid with rvalid_o (0 for writes)
//  err_o           out  1                     resp!=OKAY, valid with rvalid_o
//  axi_master_{aw,ar}_{valid,ready,addr,size,id}, w_{valid,ready,data,strb,last}, b_{valid,ready,resp}, r_{valid,ready,data,resp}: std AXI4 widths
//  axi_master_{aw,ar}_{prot,region,len,burst,lock,cache,qos,user}, w_user: out, tied 0
// BEHAVIOUR
//  Reset (axi_aresetn=0 at posedge): state=IDLE, rr_ptr=0, all gnt/rvalid/valid/ready outs 0, rdata_o=0, err_o=0.
//  FSM IDLE -> ADDR -> (WDATA if write) -> RESP -> IDLE.
//  IDLE: if |req_i, winner = first set bit at/after rr_ptr (wrap); gnt_o[winner]=1 combinationally;
//    latch owner, we, addr, wdata, be, size; go ADDR. No req -> stay.
//  ADDR: aw_valid (write) or ar_valid (read) =1, addr/size from latch, id=owner zero-ext;
//    on ready: write->WDATA, read->RESP. valid held until ready; latched fields stable.
//  WDATA: w_valid=1, w_data/w_strb latched, w_last=1; on w_ready -> RESP.
//  RESP: b_ready or r_ready =1; on valid: next cycle rvalid_o[owner]=1, rdata_o=r_data (read) or 0,
//    err_o=(resp!=2'b00); rr_ptr=(owner+1)%NUM_REQ; go IDLE. r_last, r_id, b_id ignored (single outstanding).
//  Latency, all-ready slave, read: gnt c0, ar hs c1, r hs c2, rvalid_o c3. Write: gnt c0, aw c1, w c2, b c3, rvalid_o c4.
//  rvalid_o pulse coincides with IDLE; a waiting req may be granted that same cycle (back-to-back, no bubble).
//  rr_ptr updates only on completion; a requester cannot win twice while another has req asserted.
//  gnt_o never asserted outside IDLE; requests arriving mid-transaction wait.
//  req_i dropped before gnt: allowed, no transaction. Non-owner req/field changes never affect in-flight transfer.
//  Mid-op reset: outputs drop at once, latch discarded; AXI slave must be reset with same reset.
//  Size/strb not cross-checked; requester supplies consistent be_i/size_i.
// STRUCTURE
//  Package adbg_axi_arb_pkg: FSM state encoding (IDLE/ADDR/WDATA/RESP), RESP_OKAY=2'b00, size codes.
//  Sub-module adbg_rr_arbiter (NUM_REQ): combinational rr pick from req+ptr -> one-hot + index.
//  Top: FSM, request latch, response register, AXI tie-offs.
// TESTING
//  Single read req0 addr 0x1000, slave rdata 0x1122334455667788 OKAY -> gnt_o=01 c0, ar_addr=0x1000, rvalid_o=01 c3, rdata_o matches.
//  req0+req1 writes held continuously, rr_ptr=0 -> grants alternate 01,10,01,10; one txn at a time.
//  Write req1 be=0xF0, slave b_resp=SLVERR -> w_strb=0xF0, aw_id=1, rvalid_o=10 with err_o=1; next OKAY clears err_o.
//  aw_ready/w_ready/r_valid stalled 5 cycles -> valids held, addr/data stable, no gnt_o, no rvalid_o until hs.
//  axi_aresetn low in WDATA -> next cycle w_valid=0, state IDLE, rr_ptr=0; fresh req0 granted normally.
//  req asserted in rvalid_o cycle -> gnt_o same cycle, ar_valid next cycle.

Source files
------------

// File: rtl/adbg_axi_arb_pkg.sv
// Shared types and constants for the debug-unit AXI arbiter.
// Covers the FSM state encoding, the AXI response code and the AXI size codes.
package adbg_axi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_WDATA = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [2:0] SIZE_1B = 3'd0;
  localparam logic [2:0] SIZE_2B = 3'd1;
  localparam logic [2:0] SIZE_4B = 3'd2;
  localparam logic [2:0] SIZE_8B = 3'd3;

endpackage

// File: rtl/adbg_axi_arbiter_if.sv
// Single-beat AXI4 master bus used by the debug arbiter.
// The master modport is the arbiter side; the slave modport is the interconnect side.
interface adbg_axi_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 3,
  parameter int USER_W = 6
);
  logic              aw_valid;
  logic              aw_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic [2:0]        aw_size;
  logic [ID_W-1:0]   aw_id;
  logic [2:0]        aw_prot;
  logic [3:0]        aw_region;
  logic [7:0]        aw_len;
  logic [1:0]        aw_burst;
  logic              aw_lock;
  logic [3:0]        aw_cache;
  logic [3:0]        aw_qos;
  logic [USER_W-1:0] aw_user;

  logic              ar_valid;
  logic              ar_ready;
  logic [ADDR_W-1:0] ar_addr;
  logic [2:0]        ar_size;
  logic [ID_W-1:0]   ar_id;
  logic [2:0]        ar_prot;
  logic [3:0]        ar_region;
  logic [7:0]        ar_len;
  logic [1:0]        ar_burst;
  logic              ar_lock;
  logic [3:0]        ar_cache;
  logic [3:0]        ar_qos;
  logic [USER_W-1:0] ar_user;

  logic                w_valid;
  logic                w_ready;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;
  logic [USER_W-1:0]   w_user;

  logic              b_valid;
  logic              b_ready;
  logic [1:0]        b_resp;

  logic              r_valid;
  logic              r_ready;
  logic [DATA_W-1:0] r_data;
  logic [1:0]        r_resp;

  modport master (
    output aw_valid, aw_addr, aw_size, aw_id, aw_prot, aw_region, aw_len, aw_burst,
           aw_lock, aw_cache, aw_qos, aw_user,
    input  aw_ready,
    output ar_valid, ar_addr, ar_size, ar_id, ar_prot, ar_region, ar_len, ar_burst,
           ar_lock, ar_cache, ar_qos, ar_user,
    input  ar_ready,
    output w_valid, w_data, w_strb, w_last, w_user,
    input  w_ready,
    input  b_valid, b_resp,
    output b_ready,
    input  r_valid, r_data, r_resp,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_addr, aw_size, aw_id, aw_prot, aw_region, aw_len, aw_burst,
           aw_lock, aw_cache, aw_qos, aw_user,
    output aw_ready,
    input  ar_valid, ar_addr, ar_size, ar_id, ar_prot, ar_region, ar_len, ar_burst,
           ar_lock, ar_cache, ar_qos, ar_user,
    output ar_ready,
    input  w_valid, w_data, w_strb, w_last, w_user,
    output w_ready,
    output b_valid, b_resp,
    input  b_ready,
    output r_valid, r_data, r_resp,
    input  r_ready
  );

endinterface

// File: rtl/adbg_rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after ptr_i, wrapping,
// returned both as a one-hot vector and as an index.
module adbg_rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  // cand[k] is the requester index k positions after the pointer, modulo NUM_REQ
  logic [IDX_W-1:0] cand [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    logic [IDX_W:0] sum;
    assign sum = {1'b0, ptr_i} + (IDX_W+1)'(gi);
    assign cand[gi] = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                                                   : IDX_W'(sum);
  end

  // Scan from the farthest candidate back to the pointer so the nearest one wins
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[cand[i]]) begin
        idx_o   = cand[i];
        valid_o = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
    assign gnt_o[gi] = valid_o && (idx_o == IDX_W'(gi));
  end

endmodule

// File: rtl/adbg_axi_arbiter.sv
// Shares one single-beat AXI4 master port between NUM_REQ debug requesters,
// round-robin, with exactly one transaction outstanding at a time.
module adbg_axi_arbiter
  import adbg_axi_arb_pkg::*;
#(
  parameter  int NUM_REQ        = 2,
  parameter  int AXI_ADDR_WIDTH = 32,
  parameter  int AXI_DATA_WIDTH = 64,
  parameter  int AXI_ID_WIDTH   = 3,
  parameter  int AXI_USER_WIDTH = 6,
  localparam int IDX_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int STRB_W         = AXI_DATA_WIDTH / 8
) (
  input  logic                               axi_aclk,
  input  logic                               axi_aresetn,
  input  logic [NUM_REQ-1:0]                 req_i,
  input  logic [NUM_REQ-1:0]                 we_i,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0]  wdata_i,
  input  logic [NUM_REQ*STRB_W-1:0]          be_i,
  input  logic [NUM_REQ*3-1:0]               size_i,
  output logic [NUM_REQ-1:0]                 gnt_o,
  output logic [NUM_REQ-1:0]                 rvalid_o,
  output logic [AXI_DATA_WIDTH-1:0]          rdata_o,
  output logic                               err_o,
  adbg_axi_arbiter_if.master                 axi_master
);

  arb_state_e                state_q, state_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]          owner_q, owner_d;
  logic                      we_q, we_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         be_q, be_d;
  logic [2:0]                size_q, size_d;
  logic [NUM_REQ-1:0]        rvalid_q, rvalid_d;
  logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic               grant;
  logic               resp_hs;
  logic [1:0]         resp_code;

  adbg_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // Grant is combinational from req_i, so it is also masked while reset is held
  assign grant     = (state_q == ST_IDLE) && arb_valid && axi_aresetn;
  assign gnt_o     = grant ? arb_gnt : '0;
  assign resp_hs   = we_q ? axi_master.b_valid : axi_master.r_valid;
  assign resp_code = we_q ? axi_master.b_resp : axi_master.r_resp;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    size_d   = size_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          owner_d = arb_idx;
          we_d    = we_i[arb_idx];
          addr_d  = addr_i[arb_idx*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
          wdata_d = wdata_i[arb_idx*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
          be_d    = be_i[arb_idx*STRB_W +: STRB_W];
          size_d  = size_i[arb_idx*3 +: 3];
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (we_q) begin
          if (axi_master.aw_ready) state_d = ST_WDATA;
        end else begin
          if (axi_master.ar_ready) state_d = ST_RESP;
        end
      end
      ST_WDATA: begin
        if (axi_master.w_ready) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (resp_hs) begin
          rvalid_d = NUM_REQ'(1) << owner_q;
          rdata_d  = we_q ? '0 : axi_master.r_data;
          err_d    = (resp_code != RESP_OKAY);
          // The pointer moves past the finishing owner, so it cannot win twice in a row
          rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      size_q   <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      size_q   <= size_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

  assign axi_master.aw_valid  = (state_q == ST_ADDR) && we_q;
  assign axi_master.aw_addr   = addr_q;
  assign axi_master.aw_size   = size_q;
  assign axi_master.aw_id     = AXI_ID_WIDTH'(owner_q);
  assign axi_master.aw_prot   = '0;
  assign axi_master.aw_region = '0;
  assign axi_master.aw_len    = '0;
  assign axi_master.aw_burst  = '0;
  assign axi_master.aw_lock   = 1'b0;
  assign axi_master.aw_cache  = '0;
  assign axi_master.aw_qos    = '0;
  assign axi_master.aw_user   = '0;

  assign axi_master.ar_valid  = (state_q == ST_ADDR) && !we_q;
  assign axi_master.ar_addr   = addr_q;
  assign axi_master.ar_size   = size_q;
  assign axi_master.ar_id     = AXI_ID_WIDTH'(owner_q);
  assign axi_master.ar_prot   = '0;
  assign axi_master.ar_region = '0;
  assign axi_master.ar_len    = '0;
  assign axi_master.ar_burst  = '0;
  assign axi_master.ar_lock   = 1'b0;
  assign axi_master.ar_cache  = '0;
  assign axi_master.ar_qos    = '0;
  assign axi_master.ar_user   = '0;

  assign axi_master.w_valid   = (state_q == ST_WDATA);
  assign axi_master.w_data    = wdata_q;
  assign axi_master.w_strb    = be_q;
  assign axi_master.w_last    = 1'b1;
  assign axi_master.w_user    = '0;

  assign axi_master.b_ready   = (state_q == ST_RESP) && we_q;
  assign axi_master.r_ready   = (state_q == ST_RESP) && !we_q;

endmodule

// File: tb/tb_adbg_axi_arbiter.sv
// Directed bench for adbg_axi_arbiter: the bench itself plays the AXI slave and
// steps through reset, round-robin, error, stall, mid-op reset and back-to-back cases.
module tb_adbg_axi_arbiter;
  import adbg_axi_arb_pkg::*;

  logic         clk = 1'b0;
  logic         aresetn;
  logic [1:0]   req;
  logic [1:0]   we;
  logic [63:0]  addr;
  logic [127:0] wdata;
  logic [15:0]  be;
  logic [5:0]   size;
  logic [1:0]   gnt;
  logic [1:0]   rvalid;
  logic [63:0]  rdata;
  logic         err;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  adbg_axi_arbiter_if #(.ADDR_W(32), .DATA_W(64), .ID_W(3), .USER_W(6)) axi ();

  adbg_axi_arbiter #(
    .NUM_REQ(2), .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(3), .AXI_USER_WIDTH(6)
  ) dut (
    .axi_aclk    (clk),
    .axi_aresetn (aresetn),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .be_i        (be),
    .size_i      (size),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .err_o       (err),
    .axi_master  (axi.master)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    axi.aw_ready = 1'b0;
    axi.ar_ready = 1'b0;
    axi.w_ready  = 1'b0;
    axi.b_valid  = 1'b0;
    axi.b_resp   = 2'b00;
    axi.r_valid  = 1'b0;
    axi.r_data   = '0;
    axi.r_resp   = 2'b00;
  endtask

  initial begin
    logic [1:0] exp_g;
    aresetn = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0; be = '0; size = {SIZE_8B, SIZE_8B};
    slave_idle();
    tick(); tick();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_aw_valid", 64'(axi.aw_valid), 64'd0);
    chk("rst_ar_valid", 64'(axi.ar_valid), 64'd0);
    chk("rst_w_valid", 64'(axi.w_valid), 64'd0);
    chk("rst_b_ready", 64'(axi.b_ready), 64'd0);
    chk("rst_r_ready", 64'(axi.r_ready), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    aresetn = 1'b1;
    tick();

    // Two writers held continuously: grants alternate, one write every 4 cycles
    we    = 2'b11;
    addr  = {32'h0000_2004, 32'h0000_2000};
    wdata = {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    be    = 16'hFFFF;
    axi.aw_ready = 1'b1; axi.w_ready = 1'b1; axi.b_valid = 1'b1; axi.b_resp = 2'b00;
    req = 2'b11;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("alt_gnt", 64'(gnt), 64'(exp_g));
      tick();
      if (k == 3) req = 2'b00;
      chk("alt_aw_valid", 64'(axi.aw_valid), 64'd1);
      chk("alt_aw_id", 64'(axi.aw_id), 64'(k % 2));
      chk("alt_busy_gnt", 64'(gnt), 64'd0);
      tick();
      chk("alt_w_valid", 64'(axi.w_valid), 64'd1);
      chk("alt_w_data", axi.w_data, (k % 2 == 0) ? 64'hAAAA_AAAA_AAAA_AAAA : 64'hBBBB_BBBB_BBBB_BBBB);
      tick();
      chk("alt_b_ready", 64'(axi.b_ready), 64'd1);
      tick();
      chk("alt_rvalid", 64'(rvalid), 64'(exp_g));
      #1;
    end
    chk("alt_idle_gnt", 64'(gnt), 64'd0);
    slave_idle();
    tick();

    // Single read from requester 0
    we = 2'b00;
    addr[31:0] = 32'h0000_1000;
    req = 2'b01;
    axi.ar_ready = 1'b1;
    #1;
    chk("rd_gnt", 64'(gnt), 64'h1);
    tick();
    req = 2'b00;
    chk("rd_ar_valid", 64'(axi.ar_valid), 64'd1);
    chk("rd_ar_addr", 64'(axi.ar_addr), 64'h1000);
    chk("rd_ar_id", 64'(axi.ar_id), 64'd0);
    chk("rd_ar_size", 64'(axi.ar_size), 64'(SIZE_8B));
    axi.r_valid = 1'b1; axi.r_data = 64'h1122_3344_5566_7788; axi.r_resp = 2'b00;
    tick();
    chk("rd_r_ready", 64'(axi.r_ready), 64'd1);
    chk("rd_ar_dropped", 64'(axi.ar_valid), 64'd0);
    chk("rd_early_rvalid", 64'(rvalid), 64'd0);
    tick();
    chk("rd_rvalid", 64'(rvalid), 64'h1);
    chk("rd_rdata", rdata, 64'h1122_3344_5566_7788);
    chk("rd_err", 64'(err), 64'd0);
    slave_idle();
    tick();
    chk("rd_rvalid_pulse", 64'(rvalid), 64'd0);

    // Write from requester 1 answered with SLVERR
    we = 2'b10;
    addr[63:32] = 32'h0000_3000;
    wdata[127:64] = 64'hCAFE_F00D_0000_0000;
    be = 16'hF0FF;
    axi.aw_ready = 1'b1; axi.w_ready = 1'b1; axi.b_valid = 1'b1; axi.b_resp = 2'b10;
    req = 2'b10;
    #1;
    chk("err_gnt", 64'(gnt), 64'h2);
    tick();
    req = 2'b00;
    chk("err_aw_valid", 64'(axi.aw_valid), 64'd1);
    chk("err_aw_id", 64'(axi.aw_id), 64'd1);
    chk("err_aw_addr", 64'(axi.aw_addr), 64'h3000);
    tick();
    chk("err_w_strb", 64'(axi.w_strb), 64'hF0);
    chk("err_w_data", axi.w_data, 64'hCAFE_F00D_0000_0000);
    chk("err_w_last", 64'(axi.w_last), 64'd1);
    tick();
    chk("err_b_ready", 64'(axi.b_ready), 64'd1);
    tick();
    chk("err_rvalid", 64'(rvalid), 64'h2);
    chk("err_err", 64'(err), 64'd1);
    chk("err_rdata", rdata, 64'd0);

    // OKAY read from requester 0 granted in the rvalid cycle; requester 1 waits, then goes back-to-back
    slave_idle();
    we = 2'b00;
    req = 2'b01;
    axi.ar_ready = 1'b1; axi.r_valid = 1'b1; axi.r_data = 64'h0123_4567_89AB_CDEF; axi.r_resp = 2'b00;
    #1;
    chk("b2b_gnt0", 64'(gnt), 64'h1);
    tick();
    req = 2'b10;
    addr[63:32] = 32'h0000_4000;
    #1;
    chk("b2b_midtxn_gnt", 64'(gnt), 64'd0);
    chk("b2b_ar_id0", 64'(axi.ar_id), 64'd0);
    tick();
    chk("b2b_resp_gnt", 64'(gnt), 64'd0);
    tick();
    chk("b2b_rvalid0", 64'(rvalid), 64'h1);
    chk("b2b_err_clear", 64'(err), 64'd0);
    chk("b2b_rdata0", rdata, 64'h0123_4567_89AB_CDEF);
    chk("b2b_gnt1", 64'(gnt), 64'h2);
    tick();
    req = 2'b00;
    chk("b2b_ar_valid1", 64'(axi.ar_valid), 64'd1);
    chk("b2b_ar_id1", 64'(axi.ar_id), 64'd1);
    chk("b2b_ar_addr1", 64'(axi.ar_addr), 64'h4000);
    tick();
    tick();
    chk("b2b_rvalid1", 64'(rvalid), 64'h2);
    slave_idle();
    tick();

    // Stalled write from requester 0 while requester 1 keeps asking
    we = 2'b11;
    addr = {32'h0000_6000, 32'h0000_5000};
    wdata[63:0] = 64'h5555_6666_7777_8888;
    be = 16'hFFFF;
    req = 2'b01;
    #1;
    chk("stl_gnt", 64'(gnt), 64'h1);
    tick();
    req = 2'b10;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stl_aw_valid", 64'(axi.aw_valid), 64'd1);
      chk("stl_aw_addr", 64'(axi.aw_addr), 64'h5000);
      chk("stl_aw_gnt", 64'(gnt), 64'd0);
      tick();
    end
    axi.aw_ready = 1'b1;
    tick();
    axi.aw_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stl_w_valid", 64'(axi.w_valid), 64'd1);
      chk("stl_w_data", axi.w_data, 64'h5555_6666_7777_8888);
      chk("stl_w_gnt", 64'(gnt), 64'd0);
      tick();
    end
    axi.w_ready = 1'b1;
    tick();
    axi.w_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stl_b_ready", 64'(axi.b_ready), 64'd1);
      chk("stl_b_rvalid", 64'(rvalid), 64'd0);
      tick();
    end
    axi.b_valid = 1'b1;
    tick();
    axi.b_valid = 1'b0;
    chk("stl_rvalid", 64'(rvalid), 64'h1);
    chk("stl_next_gnt", 64'(gnt), 64'h2);

    // Requester 1 write interrupted by reset in the data phase
    axi.aw_ready = 1'b1;
    tick();
    req = 2'b00;
    chk("mrst_aw_id", 64'(axi.aw_id), 64'd1);
    tick();
    axi.aw_ready = 1'b0;
    chk("mrst_w_valid_pre", 64'(axi.w_valid), 64'd1);
    aresetn = 1'b0;
    req = 2'b11;
    #1;
    chk("mrst_gnt_in_reset", 64'(gnt), 64'd0);
    tick();
    chk("mrst_w_valid", 64'(axi.w_valid), 64'd0);
    chk("mrst_aw_valid", 64'(axi.aw_valid), 64'd0);
    chk("mrst_b_ready", 64'(axi.b_ready), 64'd0);
    chk("mrst_rvalid", 64'(rvalid), 64'd0);
    aresetn = 1'b1;
    we = 2'b00;
    #1;
    chk("mrst_fresh_gnt", 64'(gnt), 64'h1);

    // Fresh read from requester 0 with the read data stalled; DECERR reported
    axi.ar_ready = 1'b1;
    tick();
    req = 2'b00;
    chk("rst_rd_ar_valid", 64'(axi.ar_valid), 64'd1);
    chk("rst_rd_ar_addr", 64'(axi.ar_addr), 64'h5000);
    tick();
    axi.ar_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rstl_r_ready", 64'(axi.r_ready), 64'd1);
      chk("rstl_rvalid", 64'(rvalid), 64'd0);
      tick();
    end
    axi.r_valid = 1'b1; axi.r_data = 64'hDEAD_BEEF_0000_0001; axi.r_resp = 2'b11;
    tick();
    chk("rstl_rvalid_done", 64'(rvalid), 64'h1);
    chk("rstl_rdata", rdata, 64'hDEAD_BEEF_0000_0001);
    chk("rstl_err", 64'(err), 64'd1);
    slave_idle();
    tick();
    chk("rstl_rvalid_pulse", 64'(rvalid), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
